// File: rtl/vedic_mac_acc.sv
// -----------------------------------------------------------------------------
// vedic_mac_acc
//
// Accumulates FRAME_LEN consecutive products from the pipelined vedic8x8
// multiplier into one dot-product result. The multiplier cannot stall, so
// every valid beat is always accepted. Each completed frame sum is parked in
// a one-entry output register with a valid/ready handshake. If a new result
// completes while the previous one is still unread, the old one is
// overwritten and the sticky lost flag is raised.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (highest priority)
//   prod_valid in   prod/prod_ovf carry a valid beat this cycle
//   prod       in   [PROD_W-1:0] product from the multiplier
//   prod_ovf   in   multiplier overflow flag for this beat
//   clear      in   synchronous frame abort (drops any concurrent beat)
//   res        out  [ACC_W-1:0] completed frame sum (saturated)
//   res_valid  out  res holds an unread result
//   res_ready  in   sink accepts res this cycle
//   res_sat    out  result was clamped to the maximum value
//   res_ovf    out  some beat in the frame had prod_ovf=1
//   lost       out  sticky: an unread result was overwritten
//   beat_cnt   out  [CNT_W-1:0] beats accepted in the current frame
//   busy       out  a frame is in progress (state ACCUM)
// -----------------------------------------------------------------------------
module vedic_mac_acc #(
    parameter int PROD_W    = 16,
    parameter int ACC_W     = 24,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_ovf,
    input  logic              clear,
    output logic [ACC_W-1:0]  res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_sat,
    output logic              res_ovf,
    output logic              lost,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int               SUM_W     = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;

    state_t             state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic               ovf_acc_q,   ovf_acc_d;
    logic               sat_acc_q,   sat_acc_d;
    logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [ACC_W-1:0]   res_q,       res_d;
    logic               res_valid_q, res_valid_d;
    logic               res_sat_q,   res_sat_d;
    logic               res_ovf_q,   res_ovf_d;
    logic               lost_q,      lost_d;

    logic [SUM_W-1:0]   sum;
    logic               clamp;
    logic [ACC_W-1:0]   sum_sat;

    // One extra bit catches the carry out of the accumulator. Once acc sits
    // at ACC_MAX any nonzero product clamps again, and a zero product leaves
    // it at ACC_MAX, so a saturated frame stays pinned at the maximum.
    always_comb begin
        sum     = {1'b0, acc_q} + SUM_W'(prod);
        clamp   = sum[ACC_W];
        sum_sat = clamp ? ACC_MAX : sum[ACC_W-1:0];
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // branches below leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        sat_acc_d   = sat_acc_q;
        beat_cnt_d  = beat_cnt_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        res_sat_d   = res_sat_q;
        res_ovf_d   = res_ovf_q;
        lost_d      = lost_q;

        // Sink takes the parked result; a completion below may re-raise valid.
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        if (clear) begin
            // Abort wins over a concurrent beat; the output register is untouched.
            state_d    = IDLE;
            acc_d      = '0;
            ovf_acc_d  = 1'b0;
            sat_acc_d  = 1'b0;
            beat_cnt_d = '0;
        end else if (prod_valid) begin
            unique case (state_q)
                IDLE: begin
                    // First beat is loaded, not added to whatever acc held.
                    acc_d      = ACC_W'(prod);
                    ovf_acc_d  = prod_ovf;
                    sat_acc_d  = 1'b0;
                    beat_cnt_d = CNT_W'(1);
                    state_d    = ACCUM;
                end
                ACCUM: begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        res_d       = sum_sat;
                        res_sat_d   = sat_acc_q | clamp;
                        res_ovf_d   = ovf_acc_q | prod_ovf;
                        res_valid_d = 1'b1;
                        // Overwriting a result the sink has not taken loses it.
                        lost_d      = lost_q | (res_valid_q & ~res_ready);
                        acc_d       = '0;
                        ovf_acc_d   = 1'b0;
                        sat_acc_d   = 1'b0;
                        beat_cnt_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d      = sum_sat;
                        ovf_acc_d  = ovf_acc_q | prod_ovf;
                        sat_acc_d  = sat_acc_q | clamp;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples its
    // _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            sat_acc_q   <= 1'b0;
            beat_cnt_q  <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_sat_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            sat_acc_q   <= sat_acc_d;
            beat_cnt_q  <= beat_cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_sat_q   <= res_sat_d;
            res_ovf_q   <= res_ovf_d;
            lost_q      <= lost_d;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_sat   = res_sat_q;
    assign res_ovf   = res_ovf_q;
    assign lost      = lost_q;
    assign beat_cnt  = beat_cnt_q;
    assign busy      = (state_q == ACCUM);

endmodule
